// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg -- shared types and constants for the BIST session controller.
//   SIG_W        : width of the signature register word
//   bist_state_t : controller FSM state encoding
// -----------------------------------------------------------------------------
package bist_pkg;

  localparam int SIG_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_RUN     = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } bist_state_t;

endpackage

// File: rtl/bist_ctrl_if.sv
// -----------------------------------------------------------------------------
// bist_ctrl_if -- signals between the BIST controller and its environment
// (pattern generator, signature register, test host).
//   start    : session request (level)
//   sig_in   : current signature register output
//   tpg_en   : pattern generator advance enable
//   misr_en  : signature register compaction enable
//   misr_clr : signature register synchronous clear request
//   busy     : session in progress
//   done     : session complete (level)
//   pass     : signature matched the golden value (valid while done)
//   sig_q    : signature captured at compare time
// Modports: slave = controller side, master = environment side.
// -----------------------------------------------------------------------------
interface bist_ctrl_if;
  import bist_pkg::*;

  logic             start;
  logic [SIG_W-1:0] sig_in;
  logic             tpg_en;
  logic             misr_en;
  logic             misr_clr;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] sig_q;

  modport slave (
    input  start, sig_in,
    output tpg_en, misr_en, misr_clr, busy, done, pass, sig_q
  );

  modport master (
    output start, sig_in,
    input  tpg_en, misr_en, misr_clr, busy, done, pass, sig_q
  );

endinterface

// File: rtl/bist_cnt.sv
// -----------------------------------------------------------------------------
// bist_cnt -- per-state cycle counter with terminal-count compare.
//   CLK    : clock, rising edge
//   RST_N  : asynchronous active-low reset
//   load   : restart at 0 on the next edge (asserted when the FSM changes state)
//   tc_val : count value marking the last cycle of the current state
//   tc     : high while the count equals tc_val
// The count saturates at all-ones so it can never wrap inside a state.
// -----------------------------------------------------------------------------
module bist_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/bist_ctrl.sv
// -----------------------------------------------------------------------------
// bist_ctrl -- BIST session controller.
// Sequence: IDLE -> INIT (clear signature) -> RUN (N_PATTERNS cycles, patterns
// and compaction) -> FLUSH (FLUSH_CYCLES cycles, compaction only) -> COMPARE
// (capture signature, compare with GOLDEN_SIG) -> DONE (until start drops).
// All outputs are registered and updated on the edge that enters a state.
// Ports:
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   abort : (only with BIST_CTRL_ABORT_EN) abandon the running session
//   bus   : bist_ctrl_if.slave (start, sig_in in; enables and status out)
// Optional feature macro: BIST_CTRL_ABORT_EN adds the abort input.
// -----------------------------------------------------------------------------
module bist_ctrl
  import bist_pkg::*;
#(
  parameter int               N_PATTERNS   = 1023,
  parameter int               FLUSH_CYCLES = 2,
  parameter logic [SIG_W-1:0] GOLDEN_SIG   = 10'h000
) (
  input  logic       CLK,
  input  logic       RST_N,
`ifdef BIST_CTRL_ABORT_EN
  input  logic       abort,
`endif
  bist_ctrl_if.slave bus
);

  localparam int               CNT_W      = $clog2(N_PATTERNS + FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(N_PATTERNS - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

  bist_state_t      state;
  logic             tpg_en_r;
  logic             misr_en_r;
  logic             misr_clr_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [SIG_W-1:0] sig_q_r;

  logic             tc;
  logic             abort_hit;
  logic             state_leave;
  logic [CNT_W-1:0] tc_val;

`ifdef BIST_CTRL_ABORT_EN
  assign abort_hit = abort && (state inside {ST_INIT, ST_RUN, ST_FLUSH, ST_COMPARE});
`else
  assign abort_hit = 1'b0;
`endif

  // The counter restarts whenever the FSM is about to change state, so every
  // state sees a count starting at 0 on its first cycle.
  always_comb begin
    state_leave = 1'b0;
    case (state)
      ST_IDLE:    state_leave = bus.start;
      ST_INIT:    state_leave = 1'b1;
      ST_RUN:     state_leave = tc;
      ST_FLUSH:   state_leave = tc;
      ST_COMPARE: state_leave = 1'b1;
      ST_DONE:    state_leave = !bus.start;
      default:    state_leave = 1'b1;
    endcase
    if (abort_hit) state_leave = 1'b1;
  end

  assign tc_val = (state == ST_FLUSH) ? FLUSH_LAST : RUN_LAST;

  bist_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .load   (state_leave),
    .tc_val (tc_val),
    .tc     (tc)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      tpg_en_r   <= 1'b0;
      misr_en_r  <= 1'b0;
      misr_clr_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      sig_q_r    <= '0;
    end else if (abort_hit) begin
      // sig_q keeps the last completed session's signature for debug.
      state      <= ST_IDLE;
      tpg_en_r   <= 1'b0;
      misr_en_r  <= 1'b0;
      misr_clr_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state      <= ST_INIT;
            misr_clr_r <= 1'b1;
            busy_r     <= 1'b1;
            pass_r     <= 1'b0;
          end
        end
        ST_INIT: begin
          state      <= ST_RUN;
          misr_clr_r <= 1'b0;
          tpg_en_r   <= 1'b1;
          misr_en_r  <= 1'b1;
        end
        ST_RUN: begin
          if (tc) begin
            state    <= ST_FLUSH;
            tpg_en_r <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (tc) begin
            state     <= ST_COMPARE;
            misr_en_r <= 1'b0;
          end
        end
        ST_COMPARE: begin
          state   <= ST_DONE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          sig_q_r <= bus.sig_in;
          pass_r  <= (bus.sig_in == GOLDEN_SIG);
        end
        ST_DONE: begin
          // A start level left high must not retrigger; wait for it to drop.
          if (!bus.start) begin
            state  <= ST_IDLE;
            done_r <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          tpg_en_r   <= 1'b0;
          misr_en_r  <= 1'b0;
          misr_clr_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tpg_en   = tpg_en_r;
  assign bus.misr_en  = misr_en_r;
  assign bus.misr_clr = misr_clr_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.pass     = pass_r;
  assign bus.sig_q    = sig_q_r;

endmodule
